// File: rtl/regfile_arb_pkg.sv
// Shared definitions for the register-file write arbiter.
// Contents: default address/data widths, the holding-slot record type,
// slot indices (ALU writeback = 0, memory/load writeback = 1) and an
// occupancy helper used for the pending-slot count.
package regfile_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_DATA_W = 32;

  localparam int unsigned SLOT_ALU = 0;
  localparam int unsigned SLOT_MEM = 1;

  typedef struct packed {
    logic                  full;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } slot_t;

  function automatic logic [1:0] occupancy(input logic [1:0] full);
    return {1'b0, full[0]} + {1'b0, full[1]};
  endfunction

endpackage

// File: rtl/wb_slot.sv
// One-entry writeback holding register.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   fill                accept fill_addr/fill_data this edge
//   drain               entry is being retired this edge
//   fill_addr/fill_data incoming write
//   full/addr/data      current entry
// A fill on the same edge as a drain wins, so the slot drains and refills
// without a bubble.
module wb_slot #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fill,
  input  logic              drain,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [DATA_W-1:0] fill_data,
  output logic              full,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (fill) begin
      full <= 1'b1;
      addr <= fill_addr;
      data <= fill_data;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between ALU writeback (req0)
// and load/memory writeback (req1). Each requester has a one-entry holding
// slot; the oldest full slot is retired first, with round-robin between
// slots filled on the same edge. The write port is registered.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   req0Valid/Addr/Data, req0Ready     ALU writeback handshake
//   req1Valid/Addr/Data, req1Ready     memory writeback handshake
//   writeEn/writeAddr/writeData        registered register-file write port
//   pendCount                          occupied slots (0..2), registered
// Optional (macro RFARB_BYPASS_EN):
//   readAddr1/2, rfData1/2 in; readData1/2 out -- forwarding of pending
//   writes onto two register-file read ports.
// Parameter DROP_ZERO: writes to address 0 retire without raising writeEn.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter bit          DROP_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0Valid,
  input  logic [ADDR_W-1:0] req0Addr,
  input  logic [DATA_W-1:0] req0Data,
  output logic              req0Ready,
  input  logic              req1Valid,
  input  logic [ADDR_W-1:0] req1Addr,
  input  logic [DATA_W-1:0] req1Data,
  output logic              req1Ready,
`ifdef RFARB_BYPASS_EN
  input  logic [ADDR_W-1:0] readAddr1,
  input  logic [ADDR_W-1:0] readAddr2,
  input  logic [DATA_W-1:0] rfData1,
  input  logic [DATA_W-1:0] rfData2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
`endif
  output logic              writeEn,
  output logic [ADDR_W-1:0] writeAddr,
  output logic [DATA_W-1:0] writeData,
  output logic [1:0]        pendCount
);

  logic [1:0]             full;
  logic [1:0]             fill;
  logic [1:0]             grant;
  logic [1:0]             nxt_full;
  logic [1:0][ADDR_W-1:0] slot_addr;
  logic [1:0][DATA_W-1:0] slot_data;

  // age_valid: both slots full and filled on different edges; age_old then
  // names the slot that was filled first.
  logic                   age_valid;
  logic                   age_old;
  logic                   rr_ptr;
  logic                   use_rr;

  logic                   sel;
  logic [ADDR_W-1:0]      win_addr;
  logic [DATA_W-1:0]      win_data;

  wb_slot #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_slot_alu (
    .clk      (clk),
    .rst_n    (rst_n),
    .fill     (fill[SLOT_ALU]),
    .drain    (grant[SLOT_ALU]),
    .fill_addr(req0Addr),
    .fill_data(req0Data),
    .full     (full[SLOT_ALU]),
    .addr     (slot_addr[SLOT_ALU]),
    .data     (slot_data[SLOT_ALU])
  );

  wb_slot #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_slot_mem (
    .clk      (clk),
    .rst_n    (rst_n),
    .fill     (fill[SLOT_MEM]),
    .drain    (grant[SLOT_MEM]),
    .fill_addr(req1Addr),
    .fill_data(req1Data),
    .full     (full[SLOT_MEM]),
    .addr     (slot_addr[SLOT_MEM]),
    .data     (slot_data[SLOT_MEM])
  );

  // Grant depends on slot state only, so ready never loops back through
  // the requesters' valid.
  always_comb begin
    grant  = '0;
    use_rr = 1'b0;
    if (full == 2'b11) begin
      if (age_valid) begin
        grant[age_old] = 1'b1;
      end else if (slot_addr[SLOT_ALU] == slot_addr[SLOT_MEM]) begin
        // Same-edge fill to one register: ALU first so the load value lands last.
        grant[SLOT_ALU] = 1'b1;
      end else begin
        grant[rr_ptr] = 1'b1;
        use_rr        = 1'b1;
      end
    end else begin
      grant = full;
    end
  end

  assign req0Ready = !full[SLOT_ALU] || grant[SLOT_ALU];
  assign req1Ready = !full[SLOT_MEM] || grant[SLOT_MEM];

  assign fill[SLOT_ALU] = req0Valid && req0Ready;
  assign fill[SLOT_MEM] = req1Valid && req1Ready;

  assign nxt_full = fill | (full & ~grant);

  assign sel      = grant[SLOT_MEM];
  assign win_addr = sel ? slot_addr[SLOT_MEM] : slot_addr[SLOT_ALU];
  assign win_data = sel ? slot_data[SLOT_MEM] : slot_data[SLOT_ALU];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_valid <= 1'b0;
      age_old   <= 1'b0;
      rr_ptr    <= 1'b0;
      writeEn   <= 1'b0;
      writeAddr <= '0;
      writeData <= '0;
      pendCount <= '0;
    end else begin
      pendCount <= occupancy(nxt_full);

      if (use_rr) begin
        rr_ptr <= ~rr_ptr;
      end

      // Both full afterwards with exactly one fresh fill: the slot that
      // stayed is older. Both fresh: fall back to round-robin. Neither
      // fresh: ordering unchanged.
      if (nxt_full == 2'b11) begin
        if (fill == 2'b11) begin
          age_valid <= 1'b0;
        end else if (fill[SLOT_ALU]) begin
          age_valid <= 1'b1;
          age_old   <= 1'b1;
        end else if (fill[SLOT_MEM]) begin
          age_valid <= 1'b1;
          age_old   <= 1'b0;
        end
      end else begin
        age_valid <= 1'b0;
      end

      if (grant != '0) begin
        writeAddr <= win_addr;
        writeData <= win_data;
        writeEn   <= !(DROP_ZERO && (win_addr == '0));
      end else begin
        writeEn <= 1'b0;
      end
    end
  end

`ifdef RFARB_BYPASS_EN
  logic                   young;
  logic                   old;
  logic [1:0][ADDR_W-1:0] rd_addr;
  logic [1:0][DATA_W-1:0] rf_data;
  logic [1:0][DATA_W-1:0] rd_data;

  // With no age ordering the slots were filled together; the memory slot
  // retires last, so it is treated as the younger value.
  assign young = age_valid ? ~age_old : 1'b1;
  assign old   = ~young;

  assign rd_addr   = {readAddr2, readAddr1};
  assign rf_data   = {rfData2, rfData1};
  assign readData1 = rd_data[0];
  assign readData2 = rd_data[1];

  always_comb begin
    rd_data = rf_data;
    for (int unsigned p = 0; p < 2; p++) begin
      if (rd_addr[p] != '0) begin
        if (full[young] && (slot_addr[young] == rd_addr[p])) begin
          rd_data[p] = slot_data[young];
        end else if (full[old] && (slot_addr[old] == rd_addr[p])) begin
          rd_data[p] = slot_data[old];
        end else if (writeEn && (writeAddr == rd_addr[p])) begin
          rd_data[p] = writeData;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
  import regfile_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0Valid, req1Valid;
  logic [4:0]  req0Addr, req1Addr;
  logic [31:0] req0Data, req1Data;
  logic        req0Ready, req1Ready;
  logic        writeEn;
  logic [4:0]  writeAddr;
  logic [31:0] writeData;
  logic [1:0]  pendCount;
`ifdef RFARB_BYPASS_EN
  logic [4:0]  readAddr1 = '0, readAddr2 = '0;
  logic [31:0] rfData1 = '0, rfData2 = '0;
  logic [31:0] readData1, readData2;
`endif

  always #5 clk = ~clk;

  regfile_write_arbiter #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .DROP_ZERO(1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0Valid(req0Valid),
    .req0Addr (req0Addr),
    .req0Data (req0Data),
    .req0Ready(req0Ready),
    .req1Valid(req1Valid),
    .req1Addr (req1Addr),
    .req1Data (req1Data),
    .req1Ready(req1Ready),
`ifdef RFARB_BYPASS_EN
    .readAddr1(readAddr1),
    .readAddr2(readAddr2),
    .rfData1  (rfData1),
    .rfData2  (rfData2),
    .readData1(readData1),
    .readData2(readData2),
`endif
    .writeEn  (writeEn),
    .writeAddr(writeAddr),
    .writeData(writeData),
    .pendCount(pendCount)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: each slot remembers the cycle it was filled; the
  // smallest fill time retires first.
  slot_t       m_slot [2];
  int          m_seq  [2];
  bit          m_rr;
  bit          m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  int          m_pend;
  int          cyc = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    int          c;
  } wr_t;
  wr_t wlog[$];

  logic last_r0, last_r1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int m_pick();
    if (m_slot[0].full && m_slot[1].full) begin
      if (m_seq[0] != m_seq[1]) return (m_seq[0] < m_seq[1]) ? 0 : 1;
      if (m_slot[0].addr == m_slot[1].addr) return 0;
      return m_rr ? 1 : 0;
    end
    if (m_slot[0].full) return 0;
    if (m_slot[1].full) return 1;
    return -1;
  endfunction

  function automatic bit m_ready(input int n);
    return !m_slot[n].full || (m_pick() == n);
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_slot[n] = '0;
      m_seq[n]  = 0;
    end
    m_rr = 0; m_we = 0; m_wa = '0; m_wd = '0; m_pend = 0;
  endtask

  task automatic model_edge();
    int          g;
    bit          acc [2];
    bit          v   [2];
    logic [4:0]  a   [2];
    logic [31:0] d   [2];
    v[0] = req0Valid; a[0] = req0Addr; d[0] = req0Data;
    v[1] = req1Valid; a[1] = req1Addr; d[1] = req1Data;
    g = m_pick();
    for (int n = 0; n < 2; n++) acc[n] = v[n] && m_ready(n);
    if (g >= 0) begin
      m_wa = m_slot[g].addr;
      m_wd = m_slot[g].data;
      m_we = (m_slot[g].addr != 5'd0);
      if (m_slot[0].full && m_slot[1].full && m_seq[0] == m_seq[1] &&
          m_slot[0].addr != m_slot[1].addr)
        m_rr = !m_rr;
    end else begin
      m_we = 0;
    end
    for (int n = 0; n < 2; n++) begin
      if (acc[n]) begin
        m_slot[n].full = 1'b1;
        m_slot[n].addr = a[n];
        m_slot[n].data = d[n];
        m_seq[n]       = cyc;
      end else if (g == n) begin
        m_slot[n].full = 1'b0;
      end
    end
    m_pend = int'(m_slot[0].full) + int'(m_slot[1].full);
    cyc++;
  endtask

  task automatic check_all();
    last_r0 = req0Ready;
    last_r1 = req1Ready;
    chk("req0Ready", 32'(req0Ready), 32'(m_ready(0)));
    chk("req1Ready", 32'(req1Ready), 32'(m_ready(1)));
    chk("writeEn",   32'(writeEn),   32'(m_we));
    chk("writeAddr", 32'(writeAddr), 32'(m_wa));
    chk("writeData", writeData,      m_wd);
    chk("pendCount", 32'(pendCount), 32'(m_pend));
    if (writeEn === 1'b1) wlog.push_back('{writeAddr, writeData, cyc});
  endtask

  // One clock: drive at the falling edge, compare, let the rising edge
  // happen, advance the model, return at the next falling edge.
  task automatic step(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                      input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                      output bit acc0, output bit acc1);
    req0Valid = v0; req0Addr = a0; req0Data = d0;
    req1Valid = v1; req1Addr = a1; req1Data = d1;
    #1;
    check_all();
    acc0 = v0 && m_ready(0);
    acc1 = v1 && m_ready(1);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit x0, x1;
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0, x0, x1);
  endtask

  task automatic async_reset();
    req0Valid = 0; req1Valid = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_writeEn",   32'(writeEn),   32'd0);
    chk("rst_pendCount", 32'(pendCount), 32'd0);
    chk("rst_req0Ready", 32'(req0Ready), 32'd1);
    chk("rst_req1Ready", 32'(req1Ready), 32'd1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit          a0c, a1c;
    bit          v0, v1, p0, p1;
    logic [4:0]  ha0, ha1;
    logic [31:0] hd0, hd1;

    rst_n = 1'b0;
    req0Valid = 0; req1Valid = 0;
    req0Addr = '0; req1Addr = '0; req0Data = '0; req1Data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("init_writeEn",   32'(writeEn),   32'd0);
    chk("init_writeAddr", 32'(writeAddr), 32'd0);
    chk("init_writeData", writeData,      32'd0);
    chk("init_pendCount", 32'(pendCount), 32'd0);
    chk("init_req0Ready", 32'(req0Ready), 32'd1);
    chk("init_req1Ready", 32'(req1Ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single write, no contention.
    step(1, 5'd4, 32'h65655555, 0, '0, '0, a0c, a1c);
    chk("t1_pend_after_accept", 32'(pendCount), 32'd1);
    chk("t1_we_after_accept",   32'(writeEn),   32'd0);
    idle(1);
    chk("t1_writeEn",   32'(writeEn),   32'd1);
    chk("t1_writeAddr", 32'(writeAddr), 32'd4);
    chk("t1_writeData", writeData,      32'h65655555);
    chk("t1_pend_done", 32'(pendCount), 32'd0);
    idle(1);

    // Address 0 is accepted but never written.
    step(1, 5'd0, 32'h00000564, 0, '0, '0, a0c, a1c);
    chk("t2_req0Ready", 32'(last_r0),   32'd1);
    chk("t2_pend",      32'(pendCount), 32'd1);
    idle(1);
    chk("t2_writeEn",   32'(writeEn),   32'd0);
    chk("t2_pend_done", 32'(pendCount), 32'd0);
    idle(1);

    // Same-edge pairs alternate via round-robin.
    wlog.delete();
    step(1, 5'd7, 32'h70, 1, 5'd9, 32'h90, a0c, a1c);
    idle(4);
    step(1, 5'd7, 32'h71, 1, 5'd9, 32'h91, a0c, a1c);
    idle(4);
    chk("t3_count", 32'(wlog.size()), 32'd4);
    if (wlog.size() == 4) begin
      chk("t3_w0", 32'(wlog[0].a), 32'd7);
      chk("t3_w1", 32'(wlog[1].a), 32'd9);
      chk("t3_w2", 32'(wlog[2].a), 32'd9);
      chk("t3_w3", 32'(wlog[3].a), 32'd7);
    end

    // Same-edge fill to one register: ALU value first, load value last.
    wlog.delete();
    step(1, 5'd5, 32'hAAAA0001, 1, 5'd5, 32'hBBBB0002, a0c, a1c);
    idle(4);
    chk("t4_count", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      chk("t4_first",  wlog[0].d, 32'hAAAA0001);
      chk("t4_second", wlog[1].d, 32'hBBBB0002);
    end
    chk("t4_final", writeData, 32'hBBBB0002);

    // Requester 1 streaming at one per cycle.
    wlog.delete();
    for (int i = 1; i <= 8; i++) begin
      step(0, '0, '0, 1, 5'd3, 32'(i), a0c, a1c);
      chk($sformatf("t5_ready_%0d", i), 32'(last_r1), 32'd1);
    end
    idle(3);
    chk("t5_count", 32'(wlog.size()), 32'd8);
    if (wlog.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("t5_data_%0d", i), wlog[i].d, 32'(i + 1));
        chk($sformatf("t5_cycle_%0d", i), 32'(wlog[i].c - wlog[0].c), 32'(i));
      end
    end

`ifdef RFARB_BYPASS_EN
    step(1, 5'd4, 32'hDEAD, 0, '0, '0, a0c, a1c);
    readAddr1 = 5'd4; rfData1 = '0;
    #1;
    chk("byp_slot", readData1, 32'hDEAD);
    readAddr1 = '0;
    idle(3);
`endif

    // Reset with both slots occupied and a write in flight.
    step(1, 5'd10, 32'h1010, 1, 5'd12, 32'h1212, a0c, a1c);
    step(1, 5'd14, 32'h1414, 1, 5'd16, 32'h1616, a0c, a1c);
    chk("t6_pend_full", 32'(pendCount), 32'd2);
    chk("t6_we_before", 32'(writeEn),   32'd1);
    async_reset();
    wlog.delete();
    idle(4);
    chk("t6_no_write", 32'(wlog.size()), 32'd0);

    // Randomized traffic with occasional resets; valid holds until accepted.
    v0 = 0; v1 = 0; p0 = 0; p1 = 0;
    ha0 = '0; ha1 = '0; hd0 = '0; hd1 = '0;
    for (int i = 0; i < 1500; i++) begin
      if (i % 500 == 250) begin
        async_reset();
        p0 = 0; p1 = 0;
        continue;
      end
      if (!p0) begin
        v0  = ($urandom_range(0, 99) < 60);
        ha0 = 5'($urandom_range(0, 7));
        hd0 = $urandom;
      end
      if (!p1) begin
        v1  = ($urandom_range(0, 99) < 60);
        ha1 = 5'($urandom_range(0, 7));
        hd1 = $urandom;
      end
      step(v0, ha0, hd0, v1, ha1, hd1, a0c, a1c);
      p0 = v0 && !a0c;
      p1 = v1 && !a1c;
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port (writeAddr/writeData/writeEn) between two writeback requesters: req0 = ALU writeback, req1 = load/memory writeback.
- One-entry holding slot per requester, oldest-first arbitration with round-robin tie-break, registered output to the register file.
- Sits between the writeback sources and register_file in the CPU datapath.

Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width.
- DROP_ZERO, 1, when 1 a write to address 0 is accepted and retired but never drives writeEn.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req0Valid  in  1  requester 0 has a write.
- req0Addr  in  ADDR_W  requester 0 destination register.
- req0Data  in  DATA_W  requester 0 data.
- req0Ready  out  1  requester 0 slot can accept.
- req1Valid, req1Addr, req1Data, req1Ready: same as req0, for requester 1.
- writeEn  out  1  register-file write enable (registered).
- writeAddr  out  ADDR_W  register-file write address (registered).
- writeData  out  DATA_W  register-file write data (registered).
- pendCount  out  2  number of occupied holding slots (0..2).

Behaviour:
- Reset (async, rst_n=0): both slots empty, age flag cleared, rrPtr=0, writeEn=0, writeAddr=0, writeData=0, pendCount=0.
- req0Ready and req1Ready are 1 whenever rst_n=0.
- Handshake: a transfer occurs on a rising edge when reqNValid && reqNReady. Valid must hold addr/data stable until accepted.
- reqNReady = !slotNFull || grantN (combinational). A slot may drain and refill in the same cycle.
- Grant (combinational from slot state only, never from inputs):
  - Only one slot full: grant it.
  - Both full, filled in different cycles: grant the older slot (age flag).
  - Both full, filled in the same cycle: grant slot rrPtr, then toggle rrPtr.
- Output stage: on the edge where slot N is granted, writeAddr<=slotN.addr and writeData<=slotN.data; the slot clears unless refilled the same edge.
  - writeEn<=1, except writeEn<=0 when DROP_ZERO=1 and addr==0.
  - No grant: writeEn<=0; writeAddr/writeData hold their last value.
- Latency: accept on edge k, writeEn high during cycle k+1, register file captures on edge k+2 (empty slot, no contention).
- Throughput: one write per cycle total; each requester is sustained at one per cycle when the other is idle.
- Same-address ordering: oldest-first guarantees program-order retire. For a same-cycle fill to the same address, req0 retires first, so req1's data is final. rrPtr is ignored in this case.
- Age flag: set to the slot that was full while the other filled; cleared when fewer than 2 slots are occupied.
- pendCount is registered and updated every edge.
- Reset mid-operation: pending slot contents are discarded and no write is issued.

Optional Feature:
- Macro: RFARB_BYPASS_EN.
- Defined: adds ports
  - readAddr1, readAddr2 (in, ADDR_W)
  - rfData1, rfData2 (in, DATA_W; raw register-file read data)
  - readData1, readData2 (out, DATA_W; combinational).
- Forwarding priority per read port:
  - younger occupied slot with matching address,
  - then older occupied slot,
  - then output stage when writeEn=1 and writeAddr matches,
  - else rfData.
  - Address 0 is never forwarded.
- Undefined: the ports above are absent, with no forwarding logic.

Decomposition:
- Package regfile_arb_pkg holds:
  - ADDR_W/DATA_W defaults,
  - slot struct typedef (full, addr, data),
  - localparams SLOT_ALU=0 and SLOT_MEM=1.
- Sub-module wb_slot: one holding register with fill/drain/refill logic, instantiated twice.
- Grant, age and rrPtr logic live in the top module.

Test Plan:
- Reset, then req0 writes addr=4, data=32'h65655555 -> writeEn=1, writeAddr=4, writeData=32'h65655555 in the cycle after accept; pendCount 1 then 0.
- req0 addr=0, data=32'h00000564 with DROP_ZERO=1 -> accepted (req0Ready=1), writeEn stays 0, pendCount returns to 0.
- Both requesters valid in the same cycle, addr 7 and 9, then repeated -> first pair retires 7 then 9, second pair 9 then 7 (round-robin alternates); no lost writes.
- Same-cycle fill to the same address: req0 addr=5, data=A and req1 addr=5, data=B -> writes in order A then B; final writeData for addr 5 is B.
- req1 valid every cycle while req0 idle, data 1..8 -> eight consecutive writeEn cycles in order; req1Ready stays 1.
- rst_n asserted low with both slots full -> writeEn=0 and pendCount=0 immediately, no write after release.
- With RFARB_BYPASS_EN: readAddr1=4 while slot holds 4/32'hDEAD, rfData1=0 -> readData1=32'hDEAD.
